// File: rtl/uart_pkg.sv
// Shared types and constants for the byte UART engine.
// Used by the top-level TX path and the RX core.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_CPB   = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF input synchroniser, falling-edge start
// detection, mid-bit sampling and stop-bit framing check.
module uart_rx_core #(
  parameter int CPB_W = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [CPB_W-1:0] cpb_eff,
  input  logic             uart_rx,
  output logic             rx_valid,
  output logic [7:0]       rx_data
);
  import uart_pkg::*;

  logic             rx_m;
  logic             rx_s;
  logic             rx_p;
  rx_state_t        st;
  rx_state_t        st_n;
  logic [CPB_W-1:0] cnt;
  logic [CPB_W-1:0] cnt_n;
  logic [CPB_W-1:0] cpb;
  logic [CPB_W-1:0] cpb_n;
  logic [2:0]       bit_i;
  logic [2:0]       bit_n;
  logic [7:0]       sh;
  logic [7:0]       sh_n;
  logic [7:0]       data_q;
  logic [7:0]       data_n;
  logic             vld_n;
  logic             bit_end;
  logic             half_end;

  assign bit_end  = (cnt == cpb - CPB_W'(1));
  assign half_end = (cnt == (cpb >> 1) - CPB_W'(1));

  always_comb begin
    st_n   = st;
    cnt_n  = bit_end ? '0 : cnt + 1'b1;
    cpb_n  = cpb;
    bit_n  = bit_i;
    sh_n   = sh;
    data_n = data_q;
    vld_n  = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_p && !rx_s) begin
          cpb_n = cpb_eff;
          st_n  = RX_START;
        end
      end
      RX_START: begin
        cnt_n = cnt + 1'b1;
        if (half_end) begin
          cnt_n = '0;
          bit_n = '0;
          // A line back high at mid-start is a glitch.
          st_n  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          sh_n = {rx_s, sh[7:1]};
          if (bit_i == 3'(UART_DATA_BITS - 1))
            st_n = RX_STOP;
          else
            bit_n = bit_i + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          if (rx_s) begin
            data_n = sh;
            vld_n  = 1'b1;
            st_n   = RX_IDLE;
          end else begin
            st_n = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_n = '0;
        if (rx_s) st_n = RX_IDLE;
      end
      default: st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_p     <= 1'b1;
      st       <= RX_IDLE;
      cnt      <= '0;
      cpb      <= CPB_W'(UART_MIN_CPB);
      bit_i    <= '0;
      sh       <= '0;
      data_q   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_m     <= uart_rx;
      rx_s     <= rx_m;
      rx_p     <= rx_s;
      st       <= st_n;
      cnt      <= cnt_n;
      cpb      <= cpb_n;
      bit_i    <= bit_n;
      sh       <= sh_n;
      data_q   <= data_n;
      rx_valid <= vld_n;
    end
  end

  assign rx_data = data_q;

endmodule

// File: rtl/uart_engine_core.sv
// Full-duplex 8N1/8N2 byte UART with runtime bit period.
// TX FSM lives here; the receiver is in uart_rx_core.
module uart_engine_core #(
  parameter int CPB_W = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [CPB_W-1:0] uart_cpb_reg,
  input  logic             uart_stp_reg,
  input  logic             data_tx_start_i,
  input  logic [7:0]       uart_tx_data_i,
  output logic             data_sent_o,
  output logic             rx_received_o,
  output logic [7:0]       rx_received_data_o,
  input  logic             uart_rx,
  output logic             uart_tx
);
  import uart_pkg::*;

  logic [CPB_W-1:0] cpb_eff;
  tx_state_t        tx_st;
  tx_state_t        tx_st_n;
  logic [CPB_W-1:0] tx_cnt;
  logic [CPB_W-1:0] tx_cnt_n;
  logic [CPB_W-1:0] tx_cpb;
  logic [CPB_W-1:0] tx_cpb_n;
  logic [2:0]       tx_bit;
  logic [2:0]       tx_bit_n;
  logic [7:0]       tx_data;
  logic [7:0]       tx_data_n;
  logic             tx_two;
  logic             tx_two_n;
  logic             tx_stp2;
  logic             tx_stp2_n;
  logic             tx_line;
  logic             tx_line_n;
  logic             tx_sent;
  logic             tx_sent_n;
  logic             tx_end;

  assign cpb_eff = (uart_cpb_reg < CPB_W'(UART_MIN_CPB))
                 ? CPB_W'(UART_MIN_CPB) : uart_cpb_reg;
  assign tx_end  = (tx_cnt == tx_cpb - CPB_W'(1));

  always_comb begin
    tx_st_n   = tx_st;
    tx_cnt_n  = tx_end ? '0 : tx_cnt + 1'b1;
    tx_cpb_n  = tx_cpb;
    tx_bit_n  = tx_bit;
    tx_data_n = tx_data;
    tx_two_n  = tx_two;
    tx_stp2_n = tx_stp2;
    tx_line_n = 1'b1;
    tx_sent_n = 1'b0;
    unique case (tx_st)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (data_tx_start_i) begin
          tx_data_n = uart_tx_data_i;
          tx_two_n  = uart_stp_reg;
          tx_cpb_n  = cpb_eff;
          tx_st_n   = TX_START;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_bit_n = '0;
          tx_st_n  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          if (tx_bit == 3'(UART_DATA_BITS - 1)) begin
            tx_stp2_n = 1'b0;
            tx_st_n   = TX_STOP;
          end else begin
            tx_bit_n = tx_bit + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_end) begin
          if (tx_two && !tx_stp2)
            tx_stp2_n = 1'b1;
          else
            tx_st_n = TX_DONE;
        end
      end
      TX_DONE: tx_st_n = TX_IDLE;
      default: tx_st_n = TX_IDLE;
    endcase
    // Line and pulse are registered from the next state.
    if (tx_st_n == TX_START)
      tx_line_n = 1'b0;
    else if (tx_st_n == TX_DATA)
      tx_line_n = tx_data_n[tx_bit_n];
    tx_sent_n = (tx_st_n == TX_DONE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      tx_st   <= TX_IDLE;
      tx_cnt  <= '0;
      tx_cpb  <= CPB_W'(UART_MIN_CPB);
      tx_bit  <= '0;
      tx_data <= '0;
      tx_two  <= 1'b0;
      tx_stp2 <= 1'b0;
      tx_line <= 1'b1;
      tx_sent <= 1'b0;
    end else begin
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_cpb  <= tx_cpb_n;
      tx_bit  <= tx_bit_n;
      tx_data <= tx_data_n;
      tx_two  <= tx_two_n;
      tx_stp2 <= tx_stp2_n;
      tx_line <= tx_line_n;
      tx_sent <= tx_sent_n;
    end
  end

  assign uart_tx     = tx_line;
  assign data_sent_o = tx_sent;

  uart_rx_core #(
    .CPB_W (CPB_W)
  ) u_rx (
    .aclk     (aclk),
    .areset   (areset),
    .cpb_eff  (cpb_eff),
    .uart_rx  (uart_rx),
    .rx_valid (rx_received_o),
    .rx_data  (rx_received_data_o)
  );

endmodule

// File: tb/tb_uart_engine_core.sv
// Bench for uart_engine_core: frame-level model checked every
// cycle, plus directed frames with literal bit/length expectations.
module tb_uart_engine_core;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] uart_cpb_reg;
  logic        uart_stp_reg;
  logic        data_tx_start_i;
  logic [7:0]  uart_tx_data_i;
  logic        data_sent_o;
  logic        rx_received_o;
  logic [7:0]  rx_received_data_o;
  logic        uart_rx;
  logic        uart_tx;

  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;
  logic        ext_push = 1'b0;
  logic [7:0]  ext_byte = 8'h00;

  assign uart_rx = loop ? uart_tx : rx_drv;

  always #5 aclk = ~aclk;

  uart_engine_core #(.CPB_W(32)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .uart_cpb_reg       (uart_cpb_reg),
    .uart_stp_reg       (uart_stp_reg),
    .data_tx_start_i    (data_tx_start_i),
    .uart_tx_data_i     (uart_tx_data_i),
    .data_sent_o        (data_sent_o),
    .rx_received_o      (rx_received_o),
    .rx_received_data_o (rx_received_data_o),
    .uart_rx            (uart_rx),
    .uart_tx            (uart_tx)
  );

  int svec = 0;
  int smiss = 0;
  int cvec = 0;
  int cmiss = 0;
  int cyc = 0;
  int pulses = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  int         m_act = 0;
  int         m_l = 0;
  int         m_c = 4;
  int         m_f = 0;
  int         m_free = 0;
  logic [7:0] m_b = 8'h00;
  logic       exp_tx = 1'b1;
  logic       exp_sent = 1'b0;
  logic [7:0] exp_last = 8'h00;

  // Frame model: a latched frame is start, 8 data, 1..2 stop
  // bits of c cycles each, then one DONE cycle with the pulse.
  always @(posedge aclk) begin : mon
    logic r, st, stp, lp, ps;
    logic [7:0] b, pb;
    int c, k;
    r   = areset;
    st  = data_tx_start_i;
    b   = uart_tx_data_i;
    stp = uart_stp_reg;
    lp  = loop;
    ps  = ext_push;
    pb  = ext_byte;
    c   = (uart_cpb_reg < 32'd4) ? 4 : int'(uart_cpb_reg);
    cyc++;
    if (r) begin
      m_act = 0;
      m_free = cyc + 1;
      exp_q.delete();
      exp_last = 8'h00;
    end else begin
      if (m_act != 0 && cyc > m_l + m_f) m_act = 0;
      if (m_act == 0 && st && cyc >= m_free) begin
        m_act = 1;
        m_l = cyc;
        m_b = b;
        m_c = c;
        m_f = (10 + int'(stp)) * c;
        m_free = cyc + m_f + 2;
        if (lp) exp_q.push_back(b);
      end
      if (ps) exp_q.push_back(pb);
    end
    exp_tx = 1'b1;
    exp_sent = 1'b0;
    if (m_act != 0) begin
      k = cyc - m_l;
      if (k < m_c) exp_tx = 1'b0;
      else if (k < 9 * m_c) exp_tx = m_b[k / m_c - 1];
      exp_sent = (k == m_f);
    end
    #1;
    cvec++;
    if (uart_tx !== exp_tx) begin
      cmiss++;
      $display("FAIL uart_tx cyc=%0d got=%b want=%b",
               cyc, uart_tx, exp_tx);
    end
    cvec++;
    if (data_sent_o !== exp_sent) begin
      cmiss++;
      $display("FAIL data_sent cyc=%0d got=%b want=%b",
               cyc, data_sent_o, exp_sent);
    end
    if (rx_received_o !== 1'b0) begin
      cvec++;
      pulses++;
      rx_log.push_back(rx_received_data_o);
      if (exp_q.size() == 0) begin
        cmiss++;
        $display("FAIL rx_pulse cyc=%0d got=pulse(%h) want=none",
                 cyc, rx_received_data_o);
      end else begin
        exp_last = exp_q.pop_front();
      end
    end
    cvec++;
    if (rx_received_data_o !== exp_last) begin
      cmiss++;
      $display("FAIL rx_data cyc=%0d got=%h want=%h",
               cyc, rx_received_data_o, exp_last);
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    svec++;
    if (got != want) begin
      smiss++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic wait_sent(input int bound);
    int n;
    n = 0;
    while (data_sent_o !== 1'b1 && n < bound) begin
      @(negedge aclk);
      n++;
    end
    chk("sent_seen", int'(data_sent_o === 1'b1), 1);
  endtask

  task automatic wait_rx_idle(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge aclk);
      n++;
    end
    chk("rx_drained", exp_q.size(), 0);
  endtask

  // Called at a negedge with the TX idle; checks mid-bit line
  // values against a literal frame and the latch-to-pulse length.
  task automatic run_frame(input logic [7:0] b, input int cpb,
                           input int ceff, input logic stp,
                           input logic [10:0] bits, input int nbits,
                           input int exp_len, input int alt_cpb);
    int k, got;
    uart_tx_data_i = b;
    uart_cpb_reg = cpb;
    uart_stp_reg = stp;
    data_tx_start_i = 1'b1;
    @(negedge aclk);
    data_tx_start_i = 1'b0;
    k = 0;
    got = -1;
    while (k <= exp_len + 4 && got < 0) begin
      if (k % ceff == ceff / 2 && k / ceff < nbits) begin
        chk("tx_bit", int'(uart_tx), int'(bits[k / ceff]));
      end
      if (k == 50 && alt_cpb > 0) uart_cpb_reg = alt_cpb;
      if (data_sent_o === 1'b1) begin
        got = k;
      end else begin
        @(negedge aclk);
        k++;
      end
    end
    chk("frame_len", got, exp_len);
    uart_cpb_reg = cpb;
  endtask

  task automatic send_rx(input logic [7:0] b, input int c,
                         input logic stopv);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx_drv = fr[j];
      repeat (c) @(negedge aclk);
    end
  endtask

  logic [7:0] t3 [4];
  int base;
  int p0;
  int ns;

  initial begin
    t3[0] = 8'h97;
    t3[1] = 8'h00;
    t3[2] = 8'hFF;
    t3[3] = 8'h13;
    uart_cpb_reg = 32'd16;
    uart_stp_reg = 1'b0;
    data_tx_start_i = 1'b0;
    uart_tx_data_i = 8'h00;

    repeat (5) @(negedge aclk);
    chk("rst_tx", int'(uart_tx), 1);
    chk("rst_sent", int'(data_sent_o), 0);
    chk("rst_rxv", int'(rx_received_o), 0);
    chk("rst_rxd", int'(rx_received_data_o), 0);
    areset = 1'b0;
    repeat (3) @(negedge aclk);

    run_frame(8'h13, 5208, 5208, 1'b0, 11'b01000100110,
              10, 52080, 0);
    repeat (3) @(negedge aclk);

    loop = 1'b1;
    base = rx_log.size();
    uart_cpb_reg = 32'd8;
    uart_stp_reg = 1'b0;
    uart_tx_data_i = t3[0];
    data_tx_start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_sent(200);
      @(negedge aclk);
      if (i < 3) uart_tx_data_i = t3[i + 1];
      else data_tx_start_i = 1'b0;
    end
    wait_rx_idle(200);
    chk("b2b_count", rx_log.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < rx_log.size())
        chk("b2b_byte", int'(rx_log[base + i]), int'(t3[i]));
    end
    repeat (3) @(negedge aclk);

    p0 = pulses;
    run_frame(8'hA5, 16, 16, 1'b1, 11'b11101001010,
              11, 176, 5);
    wait_rx_idle(200);
    chk("loop_pulses", pulses - p0, 1);
    chk("loop_data", int'(rx_received_data_o), 8'hA5);
    repeat (3) @(negedge aclk);

    loop = 1'b0;
    rx_drv = 1'b1;
    uart_cpb_reg = 32'd16;
    repeat (5) @(negedge aclk);
    p0 = pulses;
    send_rx(8'h55, 16, 1'b0);
    repeat (32) @(negedge aclk);
    rx_drv = 1'b1;
    repeat (32) @(negedge aclk);
    rx_drv = 1'b0;
    repeat (3) @(negedge aclk);
    rx_drv = 1'b1;
    repeat (40) @(negedge aclk);
    chk("bad_pulses", pulses - p0, 0);
    ext_byte = 8'h3C;
    ext_push = 1'b1;
    @(negedge aclk);
    ext_push = 1'b0;
    send_rx(8'h3C, 16, 1'b1);
    rx_drv = 1'b1;
    wait_rx_idle(200);
    chk("good_pulses", pulses - p0, 1);
    chk("good_data", int'(rx_received_data_o), 8'h3C);
    repeat (3) @(negedge aclk);

    loop = 1'b1;
    uart_cpb_reg = 32'd8;
    uart_stp_reg = 1'b0;
    uart_tx_data_i = 8'h0F;
    data_tx_start_i = 1'b1;
    @(negedge aclk);
    data_tx_start_i = 1'b0;
    repeat (43) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    chk("abort_tx", int'(uart_tx), 1);
    chk("abort_sent", int'(data_sent_o), 0);
    @(negedge aclk);
    areset = 1'b0;
    ns = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge aclk);
      if (data_sent_o === 1'b1) ns++;
    end
    chk("abort_nopulse", ns, 0);
    run_frame(8'h5A, 2, 4, 1'b1, 11'b11010110100,
              11, 44, 0);
    wait_rx_idle(200);
    chk("restart_data", int'(rx_received_data_o), 8'h5A);
    repeat (5) @(negedge aclk);

    svec += cvec;
    smiss += cmiss;
    $display("== %0d vectors applied, %0d miscompares ==",
             svec, smiss);
    $finish;
  end

endmodule
